// File: rtl/johnson_counter_param.sv
// Parametrised Johnson (twisted-ring) counter with enable, run-time direction,
// checked parallel load, self-correction of illegal codes, phase decode and wrap pulse.
module johnson_counter_param #(
  parameter int WIDTH = 4,
  parameter int PW    = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic [PW-1:0]    phase,
  output logic             wrap,
  output logic             load_err
);

  // Code that sits at phase 2*WIDTH-1; a forward step from here wraps to 0.
  localparam logic [WIDTH-1:0] LAST = WIDTH'(1);

  // A legal Johnson code has at most one 0/1 transition scanning MSB..LSB.
  function automatic logic is_legal(input logic [WIDTH-1:0] v);
    int edges;
    edges = 0;
    for (int i = 0; i < WIDTH-1; i++)
      if (v[i] != v[i+1]) edges++;
    return (edges <= 1);
  endfunction

  function automatic int popcount(input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) n++;
    return n;
  endfunction

  logic [WIDTH-1:0] fwd_next;
  logic [WIDTH-1:0] rev_next;
  logic             cur_legal;
  logic             load_legal;
  int               ones;

  always_comb begin
    fwd_next   = {~out[0], out[WIDTH-1:1]};
    rev_next   = {out[WIDTH-2:0], ~out[WIDTH-1]};
    cur_legal  = is_legal(out);
    load_legal = is_legal(load_val);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      out      <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (load_legal) begin
          out <= load_val;
        end else begin
          out      <= '0;
          load_err <= 1'b1;
        end
      end else if (en) begin
        if (!cur_legal) begin
          // Upset state: resynchronise to phase 0 instead of stepping.
          out <= '0;
        end else if (dir) begin
          out  <= rev_next;
          wrap <= (out == '0);
        end else begin
          out  <= fwd_next;
          wrap <= (out == LAST);
        end
      end
    end
  end

  // NOTE: every combinational output gets a default first so no path
  // through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    ones  = popcount(out);
    phase = '0;
    if (out[WIDTH-1])
      phase = PW'(ones);
    else if (out != '0)
      phase = PW'(2*WIDTH - ones);
  end

endmodule

// File: tb/tb_johnson_counter_param.sv
// Scoreboard bench for johnson_counter_param at WIDTH = 4, 2 and 7: the driver
// queues hand-computed expectations, a monitor compares them after each edge.
module tb_johnson_counter_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_v [3];
  logic en_v    [3];
  logic dir_v   [3];
  logic load_v  [3];
  logic [3:0] lv4;
  logic [1:0] lv2;
  logic [6:0] lv7;

  logic [3:0] out4;  logic [2:0] ph4;  logic wrap4, err4;
  logic [1:0] out2;  logic [1:0] ph2;  logic wrap2, err2;
  logic [6:0] out7;  logic [3:0] ph7;  logic wrap7, err7;

  johnson_counter_param #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset_v[0]), .en(en_v[0]), .dir(dir_v[0]), .load(load_v[0]),
    .load_val(lv4), .out(out4), .phase(ph4), .wrap(wrap4), .load_err(err4));

  johnson_counter_param #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset_v[1]), .en(en_v[1]), .dir(dir_v[1]), .load(load_v[1]),
    .load_val(lv2), .out(out2), .phase(ph2), .wrap(wrap2), .load_err(err2));

  johnson_counter_param #(.WIDTH(7)) dut7 (
    .clk(clk), .reset(reset_v[2]), .en(en_v[2]), .dir(dir_v[2]), .load(load_v[2]),
    .load_val(lv7), .out(out7), .phase(ph7), .wrap(wrap7), .load_err(err7));

  typedef struct {
    int          id;
    logic [31:0] out;
    logic [31:0] phase;
    logic        wrap;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: one expectation is consumed per driven edge, sampled 1 ns after it.
  initial begin
    exp_t        e;
    logic [31:0] a_out, a_ph;
    logic        a_w, a_e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.id)
          0:       begin a_out = 32'(out4); a_ph = 32'(ph4); a_w = wrap4; a_e = err4; end
          1:       begin a_out = 32'(out2); a_ph = 32'(ph2); a_w = wrap2; a_e = err2; end
          default: begin a_out = 32'(out7); a_ph = 32'(ph7); a_w = wrap7; a_e = err7; end
        endcase
        check({e.name, ".out"},      a_out, e.out);
        check({e.name, ".phase"},    a_ph,  e.phase);
        check({e.name, ".wrap"},     32'(a_w), 32'(e.wrap));
        check({e.name, ".load_err"}, 32'(a_e), 32'(e.err));
      end
    end
  end

  // Driver: apply one cycle of inputs to instance `id` (others idle) and queue the result.
  task automatic step(input int id, input logic r, input logic e, input logic d,
                      input logic l, input logic [31:0] lv,
                      input logic [31:0] eo, input logic [31:0] ep,
                      input logic ew, input logic ee, input string nm);
    exp_t x;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      reset_v[i] = 1'b0; en_v[i] = 1'b0; dir_v[i] = 1'b0; load_v[i] = 1'b0;
    end
    reset_v[id] = r; en_v[id] = e; dir_v[id] = d; load_v[id] = l;
    lv4 = lv[3:0]; lv2 = lv[1:0]; lv7 = lv[6:0];
    x.id = id; x.out = eo; x.phase = ep; x.wrap = ew; x.err = ee; x.name = nm;
    sb.push_back(x);
  endtask

  logic [3:0] fw4 [8]  = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                           4'b0111, 4'b0011, 4'b0001, 4'b0000};
  logic [1:0] fw2 [4]  = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [6:0] fw7 [14] = '{7'b1000000, 7'b1100000, 7'b1110000, 7'b1111000,
                           7'b1111100, 7'b1111110, 7'b1111111, 7'b0111111,
                           7'b0011111, 7'b0001111, 7'b0000111, 7'b0000011,
                           7'b0000001, 7'b0000000};

  initial begin
    int budget;
    for (int i = 0; i < 3; i++) begin
      reset_v[i] = 1'b1; en_v[i] = 1'b0; dir_v[i] = 1'b0; load_v[i] = 1'b0;
    end
    lv4 = '0; lv2 = '0; lv7 = '0;

    // WIDTH=4: reset, then full forward sweep with wrap on return to 0000.
    step(0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0, "w4_reset");
    for (int k = 0; k < 8; k++)
      step(0, 0, 1, 0, 0, 0, 32'(fw4[k]), 32'((k + 1) % 8), (k == 7), 0, "w4_fwd");

    // Reverse from 0000: wrap only on the first step.
    step(0, 0, 1, 1, 0, 0, 32'b0001, 7, 1, 0, "w4_rev0");
    step(0, 0, 1, 1, 0, 0, 32'b0011, 6, 0, 0, "w4_rev1");
    step(0, 0, 1, 1, 0, 0, 32'b0111, 5, 0, 0, "w4_rev2");

    // Hold at 0111.
    for (int k = 0; k < 5; k++)
      step(0, 0, 0, 0, 0, 0, 32'b0111, 5, 0, 0, "w4_hold");

    // Legal load wins over en; next forward step continues from it.
    step(0, 0, 1, 1, 1, 32'b0011, 32'b0011, 6, 0, 0, "w4_load_ok");
    step(0, 0, 1, 0, 0, 0, 32'b0001, 7, 0, 0, "w4_after_load");

    // Illegal load: clears, load_err for exactly one cycle, no wrap.
    step(0, 0, 0, 0, 1, 32'b0101, 32'b0000, 0, 0, 1, "w4_load_bad");
    step(0, 0, 0, 0, 0, 0, 32'b0000, 0, 0, 0, "w4_err_clear");
    step(0, 0, 1, 0, 1, 32'b1001, 32'b0000, 0, 0, 1, "w4_load_bad_en");

    // Reset mid-sequence with en: no step, no wrap.
    step(0, 0, 0, 0, 1, 32'b1110, 32'b1110, 3, 0, 0, "w4_load_1110");
    step(0, 1, 1, 0, 0, 0, 32'b0000, 0, 0, 0, "w4_reset_en");
    step(0, 1, 0, 0, 1, 32'b0111, 32'b0000, 0, 0, 0, "w4_reset_over_load");

    // Direction change with no dead cycle; reverse 1->0 is not a wrap, 0->7 is.
    step(0, 0, 1, 0, 0, 0, 32'b1000, 1, 0, 0, "w4_dir_f");
    step(0, 0, 1, 1, 0, 0, 32'b0000, 0, 0, 0, "w4_dir_r");
    step(0, 0, 1, 1, 0, 0, 32'b0001, 7, 1, 0, "w4_dir_rwrap");
    step(0, 0, 1, 0, 0, 0, 32'b0000, 0, 1, 0, "w4_dir_fwrap");

    // WIDTH=2 sweep.
    step(1, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0, "w2_reset");
    for (int k = 0; k < 4; k++)
      step(1, 0, 1, 0, 0, 0, 32'(fw2[k]), 32'((k + 1) % 4), (k == 3), 0, "w2_fwd");

    // WIDTH=7 sweep, then reverse wrap from 0.
    step(2, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0, "w7_reset");
    for (int k = 0; k < 14; k++)
      step(2, 0, 1, 0, 0, 0, 32'(fw7[k]), 32'((k + 1) % 14), (k == 13), 0, "w7_fwd");
    step(2, 0, 1, 1, 0, 0, 32'b0000001, 13, 1, 0, "w7_rev_wrap");
    step(2, 0, 0, 0, 1, 32'b0110000, 32'b0000000, 0, 0, 1, "w7_load_bad");

    // Let the monitor drain the queue within a bounded number of cycles.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      reset_v[i] = 1'b0; en_v[i] = 1'b0; load_v[i] = 1'b0;
    end
    budget = 10;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/johnson_counter_param.md
Name: johnson_counter_param

Overview:
- Parametrised Johnson (twisted-ring) counter, successor to the fixed 4-bit version. Generic WIDTH.
- Adds count enable, run-time direction, parallel load with legality check, self-correction of illegal states, a decoded phase index and a wrap pulse.
- Used as a glitch-free multi-phase sequencer and timing generator. A decoded phase feeds downstream compare and select logic.

Parameters:
- WIDTH, 4, ring length in bits; legal range 2..32; sequence length 2*WIDTH.
- PW, $clog2(2*WIDTH), phase index width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- en  in  1  advance one step this cycle
- dir  in  1  0 = forward, 1 = reverse
- load  in  1  parallel load request
- load_val  in  WIDTH  value to load
- out  out  WIDTH  registered counter state
- phase  out  PW  combinational decode of out, 0..2*WIDTH-1
- wrap  out  1  registered one-cycle pulse on sequence wrap
- load_err  out  1  registered one-cycle pulse on illegal load

Behaviour:
- All state updates on posedge clk only. Priority: reset > load > en > hold.
- reset=1: out=0, wrap=0, load_err=0 on the next edge. A reset mid-sequence discards state; no partial step.
- Forward step (en=1, dir=0): out <= {~out[0], out[WIDTH-1:1]}. Identical sequence to the existing 4-bit counter.
- Reverse step (en=1, dir=1): out <= {out[WIDTH-2:0], ~out[WIDTH-1]}. This is the exact inverse of the forward step.
- dir may change on any cycle. The new direction applies from that edge; there is no dead cycle.
- en=0 with load=0: out holds. wrap=0 and load_err=0.
- Legal code: out contains at most one 0/1 transition in the linear bit order MSB..LSB. There are exactly 2*WIDTH legal codes.
- load=1 with legal load_val: out <= load_val and load_err=0. en is ignored that cycle.
- load=1 with illegal load_val: out <= 0 and load_err=1 for one cycle.
- Self-correction: if en=1 and the current out is illegal (e.g. upset), out <= 0 instead of stepping. load_err is not asserted.
- Phase decode, combinational, same cycle as out:
  - out[WIDTH-1]=1: phase = popcount(out).
  - else if out=0: phase = 0.
  - else: phase = 2*WIDTH - popcount(out).
  - Phase is don't-care while out is illegal.
- Forward step increments phase mod 2*WIDTH. Reverse step decrements phase mod 2*WIDTH.
- wrap is registered and asserted the cycle after either of these steps:
  - a forward step from phase 2*WIDTH-1 to 0;
  - a reverse step from phase 0 to 2*WIDTH-1.
- wrap is never asserted on load, reset or self-correction.
- Latency: out and wrap update 1 cycle after the input edge. phase follows out with 0 cycles of additional delay.
- No X propagation: every output is defined from the first reset onward.

Test Plan:
- WIDTH=4, reset, then en=1, dir=0 for 8 clocks:
  - out = 1000,1100,1110,1111,0111,0011,0001,0000.
  - phase = 1..7,0.
  - wrap=1 only in the cycle out returns to 0000.
- From 0000, en=1, dir=1 for 3 clocks -> out = 0001,0011,0111; phase = 7,6,5; wrap=1 in the first cycle only.
- load=1, load_val=0011, en=1 -> out=0011, phase=6, load_err=0; next en cycle with dir=0 -> 0001.
- load=1, load_val=0101 -> out=0000, load_err=1 for exactly one cycle, wrap=0.
- Mid-sequence at out=1110, assert reset and en together -> out=0000 next edge, no wrap.
- Hold and WIDTH sweep:
  - en=0 for 5 cycles at out=0111 -> out stable, wrap=0.
  - Repeat the forward 2*WIDTH sweep with WIDTH=2 (00,10,11,01,00) and WIDTH=7.
